ctrl_varredura_7seg: RTL and testbench

Time-multiplexed scan controller that shares one BCD-to-7-segment decode path across N_DIGITOS common-driven digits.
- Holds a double-buffered digit frame and cycles a one-hot digit select with a programmable dwell time.
- Inserts a blanking guard interval between digits to prevent ghosting.
- Sits between the numeric datapath (BCD producers) and the board's segment/anode pins.

---
 rtl/disp_pkg.sv | 34 +++
 rtl/bcd_para_7seg.sv | 37 +++
 rtl/ctrl_varredura_7seg.sv | 216 +++++++++++++++++++++
 tb/tb_ctrl_varredura_7seg.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   - SEG_0..SEG_9, SEG_APAGADO : segment patterns, index order [0:6] = a..g,
//                                 active-high.
//   - estado_t                  : scan FSM states.
//   - largura_indice()          : width of the digit index (minimum 1 bit).
// ----------------------------------------------------------------------------
package disp_pkg;

    localparam logic [0:6] SEG_0       = 7'b1111110;
    localparam logic [0:6] SEG_1       = 7'b0110000;
    localparam logic [0:6] SEG_2       = 7'b1101101;
    localparam logic [0:6] SEG_3       = 7'b1111001;
    localparam logic [0:6] SEG_4       = 7'b0110011;
    localparam logic [0:6] SEG_5       = 7'b1011011;
    localparam logic [0:6] SEG_6       = 7'b1011111;
    localparam logic [0:6] SEG_7       = 7'b1110000;
    localparam logic [0:6] SEG_8       = 7'b1111111;
    localparam logic [0:6] SEG_9       = 7'b1111011;
    localparam logic [0:6] SEG_APAGADO = 7'b0000000;

    typedef enum logic [1:0] {
        DESLIGADO = 2'd0,
        GUARDA    = 2'd1,
        MOSTRA    = 2'd2
    } estado_t;

    // A single digit still needs a 1-bit index port.
    function automatic int largura_indice(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_para_7seg.sv
// ----------------------------------------------------------------------------
// bcd_para_7seg
// Combinational BCD to 7-segment decoder. Codes 10..15 decode to blank.
// Ports:
//   codigo    in  [3:0]  BCD code
//   apagar    in  1      force blank output
//   segmentos out [0:6]  segments a..g, active-high
// ----------------------------------------------------------------------------
module bcd_para_7seg
    import disp_pkg::*;
(
    input  logic [3:0] codigo,
    input  logic       apagar,
    output logic [0:6] segmentos
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        segmentos = SEG_APAGADO;
        if (!apagar) begin
            case (codigo)
                4'd0:    segmentos = SEG_0;
                4'd1:    segmentos = SEG_1;
                4'd2:    segmentos = SEG_2;
                4'd3:    segmentos = SEG_3;
                4'd4:    segmentos = SEG_4;
                4'd5:    segmentos = SEG_5;
                4'd6:    segmentos = SEG_6;
                4'd7:    segmentos = SEG_7;
                4'd8:    segmentos = SEG_8;
                4'd9:    segmentos = SEG_9;
                default: segmentos = SEG_APAGADO;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_varredura_7seg.sv
// ----------------------------------------------------------------------------
// ctrl_varredura_7seg
// Time-multiplexed scan controller for N_DIGITOS common-driven 7-segment
// digits sharing one decoder. Each digit is shown for PRESCALE cycles, with
// GUARDA dark cycles before it to avoid ghosting. The digit frame is double
// buffered: new data is staged and only moved to the display at a frame
// boundary (end of the last digit) or while the display is off.
//
// Optional build macro: SUPRIME_ZEROS_EN -- leading-zero blanking (digit 0 is
// always shown; anode timing is unchanged).
//
// Ports:
//   clk        in   1            system clock, rising edge
//   rst        in   1            asynchronous reset, active-high
//   ena        in   1            scan enable, 0 = display dark
//   dados      in   4*N_DIGITOS  BCD digits, digit k = dados[4k+3:4k]
//   carrega    in   1            load strobe for dados
//   pendente   out  1            staged frame not yet applied
//   atualizado out  1            pulse when staged frame becomes displayed
//   segmentos  out  [0:6]        segments a..g, active-high, registered
//   anodos     out  N_DIGITOS    one-hot digit select, registered
//   indice     out  >=1 bit      digit currently selected
// ----------------------------------------------------------------------------
module ctrl_varredura_7seg
    import disp_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int PRESCALE  = 50000,
    parameter int GUARDA    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ena,
    input  logic [4*N_DIGITOS-1:0]               dados,
    input  logic                                 carrega,
    output logic                                 pendente,
    output logic                                 atualizado,
    output logic [0:6]                           segmentos,
    output logic [N_DIGITOS-1:0]                 anodos,
    output logic [largura_indice(N_DIGITOS)-1:0] indice
);

    localparam int IW   = largura_indice(N_DIGITOS);
    localparam int MAXC = (PRESCALE > GUARDA) ? PRESCALE : GUARDA;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]        FIM_MOSTRA = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]        FIM_GUARDA = CW'((GUARDA > 0) ? GUARDA - 1 : 0);
    localparam logic [IW-1:0]        ULTIMO     = IW'(N_DIGITOS - 1);
    localparam logic [N_DIGITOS-1:0] UM_HOT     = N_DIGITOS'(1);

    // The GUARDA parameter hides the enum literal of the same name, so the
    // state is always written with the package scope.
    localparam estado_t APOS_DIGITO = (GUARDA > 0) ? disp_pkg::GUARDA : MOSTRA;

    estado_t estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] indice_d;

    logic [N_DIGITOS-1:0][3:0] display_q, display_d;
    logic [N_DIGITOS-1:0][3:0] staging_q, staging_d;
    logic                      pendente_d;
    logic                      atualizado_d;

    logic                 fim_mostra;
    logic                 ponto_aplicacao;
    logic [3:0]           digito_sel;
    logic                 apagar;
    logic [0:6]           seg_dec;
    logic [0:6]           segmentos_d;
    logic [N_DIGITOS-1:0] anodos_d;

    // ------------------------------------------------------------------
    // Scan FSM: next state, dwell counter, digit index
    // ------------------------------------------------------------------
    assign fim_mostra = (estado_q == MOSTRA) && (cnt_q == FIM_MOSTRA);

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        indice_d = indice;
        if (!ena) begin
            estado_d = DESLIGADO;
            cnt_d    = '0;
            indice_d = '0;
        end else begin
            case (estado_q)
                DESLIGADO: begin
                    estado_d = APOS_DIGITO;
                    cnt_d    = '0;
                    indice_d = '0;
                end
                disp_pkg::GUARDA: begin
                    if (cnt_q == FIM_GUARDA) begin
                        estado_d = MOSTRA;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                MOSTRA: begin
                    if (fim_mostra) begin
                        estado_d = APOS_DIGITO;
                        cnt_d    = '0;
                        indice_d = (indice == ULTIMO) ? '0 : indice + IW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    estado_d = DESLIGADO;
                    cnt_d    = '0;
                    indice_d = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load handshake. The displayed frame only changes at a frame boundary
    // or while dark, so a digit never mixes two frames within one scan.
    // ------------------------------------------------------------------
    assign ponto_aplicacao = (estado_q == DESLIGADO) || (fim_mostra && (indice == ULTIMO));

    always_comb begin
        display_d    = display_q;
        staging_d    = staging_q;
        pendente_d   = pendente;
        atualizado_d = 1'b0;
        if (ponto_aplicacao) begin
            if (carrega) begin
                // Data arriving exactly at the apply point skips staging.
                display_d    = dados;
                pendente_d   = 1'b0;
                atualizado_d = 1'b1;
            end else if (pendente) begin
                display_d    = staging_q;
                pendente_d   = 1'b0;
                atualizado_d = 1'b1;
            end
        end else if (carrega) begin
            staging_d  = dados;
            pendente_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output path, decoded from next-state values so that anodes and
    // segments switch on the same edge.
    // ------------------------------------------------------------------
    assign digito_sel = display_d[indice_d];

`ifdef SUPRIME_ZEROS_EN
    logic [N_DIGITOS-1:0] supressao;
    logic                 zeros_acima;

    always_comb begin
        supressao   = '0;
        zeros_acima = 1'b1;
        // NOTE: blocking assignments here are intentional: zeros_acima carries a running AND from the top digit down within one evaluation.
        for (int k = N_DIGITOS - 1; k >= 1; k--) begin
            zeros_acima  = zeros_acima & (display_d[k] == 4'd0);
            supressao[k] = zeros_acima;
        end
    end

    assign apagar = supressao[indice_d];
`else
    assign apagar = 1'b0;
`endif

    bcd_para_7seg u_decodificador (
        .codigo    (digito_sel),
        .apagar    (apagar),
        .segmentos (seg_dec)
    );

    always_comb begin
        anodos_d    = '0;
        segmentos_d = SEG_APAGADO;
        if (estado_d == MOSTRA) begin
            anodos_d    = UM_HOT << indice_d;
            segmentos_d = seg_dec;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the frame buffers are a few flip-flops rather than a RAM, so they are reset along with the control state.
        if (rst) begin
            estado_q   <= DESLIGADO;
            cnt_q      <= '0;
            indice     <= '0;
            display_q  <= '0;
            staging_q  <= '0;
            pendente   <= 1'b0;
            atualizado <= 1'b0;
            anodos     <= '0;
            segmentos  <= SEG_APAGADO;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            indice     <= indice_d;
            display_q  <= display_d;
            staging_q  <= staging_d;
            pendente   <= pendente_d;
            atualizado <= atualizado_d;
            anodos     <= anodos_d;
            segmentos  <= segmentos_d;
        end
    end

endmodule

// File: tb/tb_ctrl_varredura_7seg.sv
// ----------------------------------------------------------------------------
// tb_ctrl_varredura_7seg
// Self-checking bench for ctrl_varredura_7seg with N_DIGITOS=4, PRESCALE=3,
// GUARDA=1. A cycle-position reference model pushes the expected outputs of
// every clock into a scoreboard queue; each is popped and compared one
// sampling point after the edge. A vector table checks decoded frames, and
// hand-written sequences cover reload, enable drop and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_ctrl_varredura_7seg;

    localparam int N   = 4;
    localparam int P   = 3;
    localparam int G   = 1;
    localparam int SLT = P + G;     // cycles per digit slot
    localparam int PER = N * SLT;   // cycles per frame

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        carrega;
    logic [15:0] dados;
    logic        pendente;
    logic        atualizado;
    logic [0:6]  segmentos;
    logic [3:0]  anodos;
    logic [1:0]  indice;

    always #5 clk = ~clk;

    ctrl_varredura_7seg #(
        .N_DIGITOS (N),
        .PRESCALE  (P),
        .GUARDA    (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .dados      (dados),
        .carrega    (carrega),
        .pendente   (pendente),
        .atualizado (atualizado),
        .segmentos  (segmentos),
        .anodos     (anodos),
        .indice     (indice)
    );

    typedef struct packed {
        logic [3:0] anod;
        logic [0:6] seg;
        logic [1:0] idx;
        logic       pend;
        logic       atu;
    } saida_t;

    typedef struct packed {
        logic [15:0]     dados;
        logic [3:0][0:6] seg;    // expected segments of digit k
    } vetor_t;

    saida_t     fila[$];
    vetor_t     tabela[3];
    logic [0:6] mapa[16];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: m_pos is the position inside the frame of the
    // cycle currently on the outputs (slot start = guard cycle).
    bit          m_on;
    int          m_pos;
    logic [15:0] m_disp;
    logic [15:0] m_stg;
    bit          m_pend;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_vec++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic [0:6] seg_esperado(input logic [15:0] frame, input int k);
        logic [3:0] codigo;
        codigo = frame[4*k +: 4];
`ifdef SUPRIME_ZEROS_EN
        if (k > 0 && (frame >> (4*k)) == 16'h0) return 7'b0000000;
`endif
        return mapa[codigo];
    endfunction

    task automatic modelo(input logic e, input logic c, input logic [15:0] d);
        saida_t s;
        bit     ap;
        int     dig;
        ap    = !m_on || (m_pos == PER - 1);
        s     = '0;
        if (ap) begin
            if (c) begin
                m_disp = d; m_pend = 0; s.atu = 1'b1;
            end else if (m_pend) begin
                m_disp = m_stg; m_pend = 0; s.atu = 1'b1;
            end
        end else if (c) begin
            m_stg = d; m_pend = 1;
        end
        if (!e)         m_on = 0;
        else if (!m_on) begin m_on = 1; m_pos = 0; end
        else            m_pos = (m_pos + 1) % PER;
        s.pend = m_pend;
        if (m_on) begin
            dig   = m_pos / SLT;
            s.idx = 2'(dig);
            if ((m_pos % SLT) >= G) begin
                s.anod = 4'b0001 << dig;
                s.seg  = seg_esperado(m_disp, dig);
            end
        end
        fila.push_back(s);
    endtask

    task automatic passo(input logic e, input logic c, input logic [15:0] d);
        saida_t x;
        ena     = e;
        carrega = c;
        dados   = d;
        modelo(e, c, d);
        @(posedge clk);
        #1;
        x = fila.pop_front();
        check("anodos",     32'(anodos),     32'(x.anod));
        check("segmentos",  32'(segmentos),  32'(x.seg));
        check("indice",     32'(indice),     32'(x.idx));
        check("pendente",   32'(pendente),   32'(x.pend));
        check("atualizado", 32'(atualizado), 32'(x.atu));
    endtask

    task automatic ate_pos(input int p);
        for (int i = 0; i < 2 * PER && !(m_on && m_pos == p); i++) passo(1'b1, 1'b0, 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulsos;

        mapa[0]  = 7'b1111110; mapa[1]  = 7'b0110000; mapa[2]  = 7'b1101101;
        mapa[3]  = 7'b1111001; mapa[4]  = 7'b0110011; mapa[5]  = 7'b1011011;
        mapa[6]  = 7'b1011111; mapa[7]  = 7'b1110000; mapa[8]  = 7'b1111111;
        mapa[9]  = 7'b1111011;
        for (int i = 10; i < 16; i++) mapa[i] = 7'b0000000;

        tabela[0].dados  = 16'h00AF;
        tabela[0].seg[0] = 7'b0000000;
        tabela[0].seg[1] = 7'b0000000;
`ifdef SUPRIME_ZEROS_EN
        tabela[0].seg[2] = 7'b0000000;
        tabela[0].seg[3] = 7'b0000000;
`else
        tabela[0].seg[2] = 7'b1111110;
        tabela[0].seg[3] = 7'b1111110;
`endif
        tabela[1].dados  = 16'h9876;
        tabela[1].seg[0] = 7'b1011111;
        tabela[1].seg[1] = 7'b1110000;
        tabela[1].seg[2] = 7'b1111111;
        tabela[1].seg[3] = 7'b1111011;
        tabela[2].dados  = 16'h0050;
        tabela[2].seg[0] = 7'b1111110;
        tabela[2].seg[1] = 7'b1011011;
`ifdef SUPRIME_ZEROS_EN
        tabela[2].seg[2] = 7'b0000000;
        tabela[2].seg[3] = 7'b0000000;
`else
        tabela[2].seg[2] = 7'b1111110;
        tabela[2].seg[3] = 7'b1111110;
`endif

        m_on = 0; m_pos = 0; m_disp = '0; m_stg = '0; m_pend = 0;

        // Reset state
        rst = 1'b1; ena = 1'b0; carrega = 1'b0; dados = '0;
        #12;
        check("rst_anodos",     32'(anodos),     32'h0);
        check("rst_segmentos",  32'(segmentos),  32'h0);
        check("rst_indice",     32'(indice),     32'h0);
        check("rst_pendente",   32'(pendente),   32'h0);
        check("rst_atualizado", 32'(atualizado), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: load while dark, then scan two full frames
        passo(1'b1, 1'b1, 16'h1234);
        check("s1_atualizado", 32'(atualizado), 32'h1);
        check("s1_guard_dark", 32'(anodos),     32'h0);
        ate_pos(1);
        check("s1_d0_anodos", 32'(anodos),    32'h1);
        check("s1_d0_seg4",   32'(segmentos), 32'(7'b0110011));
        ate_pos(13);
        check("s1_d3_anodos", 32'(anodos),    32'h8);
        check("s1_d3_seg1",   32'(segmentos), 32'(7'b0110000));
        for (int i = 0; i < PER; i++) passo(1'b1, 1'b0, 16'h0);

        // 2: mid-frame load waits for the frame boundary
        ate_pos(5);
        passo(1'b1, 1'b1, 16'h5678);
        check("s2_pendente", 32'(pendente), 32'h1);
        ate_pos(9);
        check("s2_d2_still2", 32'(segmentos), 32'(7'b1101101));
        ate_pos(13);
        check("s2_d3_still1", 32'(segmentos), 32'(7'b0110000));
        ate_pos(15);
        passo(1'b1, 1'b0, 16'h0);
        check("s2_atualizado", 32'(atualizado), 32'h1);
        check("s2_pend_clear", 32'(pendente),   32'h0);
        ate_pos(1);
        check("s2_d0_seg8", 32'(segmentos), 32'(7'b1111111));

        // 3: two loads in one frame, latest wins, single pulse
        ate_pos(2);
        passo(1'b1, 1'b1, 16'h0001);
        ate_pos(8);
        passo(1'b1, 1'b1, 16'h0009);
        pulsos = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            passo(1'b1, 1'b0, 16'h0);
            if (atualizado) pulsos++;
        end
        check("s3_pulsos", 32'(pulsos), 32'h1);
        ate_pos(1);
        check("s3_d0_seg9", 32'(segmentos), 32'(7'b1111011));

        // 4: table of frames, loaded while dark
        for (int v = 0; v < 3; v++) begin
            passo(1'b0, 1'b0, 16'h0);
            passo(1'b1, 1'b1, tabela[v].dados);
            for (int k = 0; k < N; k++) begin
                ate_pos(k * SLT + G);
                check($sformatf("tab%0d_d%0d_anodos", v, k), 32'(anodos), 32'(4'b0001 << k));
                check($sformatf("tab%0d_d%0d_seg", v, k), 32'(segmentos), 32'(tabela[v].seg[k]));
            end
        end

        // 5: drop enable while digit 2 is shown, then restart
        ate_pos(9);
        passo(1'b0, 1'b0, 16'h0);
        check("s5_dark_anodos", 32'(anodos),    32'h0);
        check("s5_dark_seg",    32'(segmentos), 32'h0);
        passo(1'b1, 1'b0, 16'h0);
        check("s5_guard_anodos", 32'(anodos), 32'h0);
        check("s5_guard_indice", 32'(indice), 32'h0);
        passo(1'b1, 1'b0, 16'h0);
        check("s5_restart_d0", 32'(anodos), 32'h1);

        // 6: asynchronous reset in the middle of a shown digit
        ate_pos(2);
        passo(1'b1, 1'b1, 16'h4321);
        ate_pos(6);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_anodos",   32'(anodos),    32'h0);
        check("s6_async_seg",      32'(segmentos), 32'h0);
        check("s6_async_pendente", 32'(pendente),  32'h0);
        m_on = 0; m_pos = 0; m_disp = '0; m_stg = '0; m_pend = 0;
        @(negedge clk);
        rst = 1'b0;
        passo(1'b1, 1'b0, 16'h0);
        ate_pos(1);
        check("s6_display_clear", 32'(segmentos), 32'(7'b1111110));
        check("s6_no_pending",    32'(pendente),  32'h0);
        for (int i = 0; i < PER; i++) passo(1'b1, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
